param_sync_fifo: RTL

- Parametrised single-clock synchronous FIFO: generalised width, depth, almost-full threshold, and occupancy count.
- Used as the standard buffering element between producer/consumer stages in testcase and std-library designs.
- First-word-fall-through read: the head entry is always visible on o_data.
- Adds synchronous flush and overflow/underflow error pulses.

---
 rtl/param_sync_fifo_if.sv | 38 +++
 rtl/param_sync_fifo.sv | 85 ++++++++
 2 files changed

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: handshake/data bundle for param_sync_fifo.
//   i_clear         synchronous flush request
//   i_push, i_data  write request and write data
//   i_pop           read request (acknowledges current head)
//   o_data          head entry (first-word-fall-through)
//   o_empty/o_full/o_almost_full/o_count  occupancy status
//   o_overflow/o_underflow                one-cycle rejection pulses
// master: producer/consumer side; slave: FIFO side.
interface param_sync_fifo_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_clear;
    logic             i_push;
    logic [WIDTH-1:0] i_data;
    logic             i_pop;
    logic [WIDTH-1:0] o_data;
    logic             o_empty;
    logic             o_full;
    logic             o_almost_full;
    logic [CW-1:0]    o_count;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_clear, i_push, i_data, i_pop,
        input  o_data, o_empty, o_full, o_almost_full, o_count,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_clear, i_push, i_data, i_pop,
        output o_data, o_empty, o_full, o_almost_full, o_count,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FWFT FIFO with arbitrary DEPTH, almost-full
// threshold, occupancy count, synchronous flush and overflow/underflow pulses.
//   i_clk  clock, rising edge
//   i_rst  asynchronous reset, active-low
//   bus    param_sync_fifo_if.slave (see interface header for signals)
module param_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int AF_TH = DEPTH - 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    param_sync_fifo_if.slave     bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic empty, full, push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = bus.i_pop & ~empty;
    assign push_ok = bus.i_push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (bus.i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (push_ok)
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop_ok)
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            ovf_d   = bus.i_push & ~push_ok;
            unf_d   = bus.i_pop & ~pop_ok;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (!bus.i_clear && push_ok)
            mem[wr_ptr_q] <= bus.i_data;
    end

    assign bus.o_data        = mem[rd_ptr_q];
    assign bus.o_empty       = empty;
    assign bus.o_full        = full;
    assign bus.o_almost_full = (count_q >= CW'(AF_TH));
    assign bus.o_count       = count_q;
    assign bus.o_overflow    = ovf_q;
    assign bus.o_underflow   = unf_q;
endmodule
